// File: rtl/merge_fixed.sv
// Sign/magnitude fixed-point to two's-complement converter with saturation.
// Two-stage valid/ready pipeline; counts saturated words delivered downstream.
module merge_fixed #(
  parameter int INT_W  = 15,
  parameter int FRAC_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_neg,
  input  logic [INT_W-1:0]          in_int,
  input  logic [FRAC_W-1:0]         in_frac,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INT_W+FRAC_W-1:0]   out_data,
  output logic                      out_ovf,
  output logic                      out_frac,
  output logic [15:0]               ovf_cnt
);

  localparam int W = INT_W + FRAC_W;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_mag_q,   s1_mag_d;
  logic         s1_neg_q,   s1_neg_d;
  logic         s1_frac_q,  s1_frac_d;
  logic         s1_ovf_q,   s1_ovf_d;

  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] s2_data_q,  s2_data_d;
  logic         s2_ovf_q,   s2_ovf_d;
  logic         s2_frac_q,  s2_frac_d;
  logic [15:0]  ovf_cnt_q,  ovf_cnt_d;

  logic         s2_adv;
  logic [W-1:0] in_mag;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_mag   = {in_int, in_frac};

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mag_d   = s1_mag_q;
    s1_neg_d   = s1_neg_q;
    s1_frac_d  = s1_frac_q;
    s1_ovf_d   = s1_ovf_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mag_d  = in_mag;
        s1_neg_d  = in_neg;
        s1_frac_d = |in_frac;
        // Negative range reaches one step further than positive range.
        s1_ovf_d  = in_neg ? (in_mag > MIN_NEG) : (in_mag > MAX_POS);
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_ovf_d   = s2_ovf_q;
    s2_frac_d  = s2_frac_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_ovf_d  = s1_ovf_q;
        s2_frac_d = s1_frac_q;
        if (s1_ovf_q)
          s2_data_d = s1_neg_q ? MIN_NEG : MAX_POS;
        else
          s2_data_d = s1_neg_q ? ((~s1_mag_q) + ONE) : s1_mag_q;
      end
    end
  end

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (s2_valid_q && out_ready && s2_ovf_q && (ovf_cnt_q != 16'hFFFF))
      ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mag_q   <= '0;
      s1_neg_q   <= 1'b0;
      s1_frac_q  <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
      s2_frac_q  <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mag_q   <= s1_mag_d;
      s1_neg_q   <= s1_neg_d;
      s1_frac_q  <= s1_frac_d;
      s1_ovf_q   <= s1_ovf_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_frac_q  <= s2_frac_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_ovf   = s2_ovf_q;
  assign out_frac  = s2_frac_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_merge_fixed.sv
// Testbench for merge_fixed: arithmetic reference model with a per-cycle
// scoreboard, plus directed literal checks for latency, stalls and reset.
module tb_merge_fixed;

  localparam int INT_W  = 15;
  localparam int FRAC_W = 10;
  localparam int W      = INT_W + FRAC_W;

  typedef struct {
    logic [W-1:0] data;
    logic         ovf;
    logic         frac;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_neg;
  logic [INT_W-1:0]  in_int;
  logic [FRAC_W-1:0] in_frac;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_ovf;
  logic              out_frac;
  logic [15:0]       ovf_cnt;

  int testsRun    = 0;
  int testsFailed = 0;
  int acceptCount = 0;
  int deliverCount = 0;
  int expCnt      = 0;
  exp_t expQ[$];

  merge_fixed #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_neg    (in_neg),
    .in_int    (in_int),
    .in_frac   (in_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_frac  (out_frac),
    .ovf_cnt   (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: value = int*2^FRAC_W + frac, signed, clamped to the W-bit range.
  function automatic exp_t model(input logic neg, input logic [INT_W-1:0] i, input logic [FRAC_W-1:0] f);
    exp_t   r;
    longint mag;
    longint half;
    longint v;
    mag    = longint'(i) * (longint'(1) << FRAC_W) + longint'(f);
    half   = longint'(1) << (W - 1);
    r.frac = (f != 0);
    r.ovf  = 1'b0;
    if (!neg) begin
      if (mag > half - 1) begin v = half - 1; r.ovf = 1'b1; end
      else v = mag;
    end else begin
      if (mag > half) begin v = -half; r.ovf = 1'b1; end
      else v = -mag;
    end
    r.data = v[W-1:0];
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t h;
    if (!rst_n) begin
      expQ.delete();
      expCnt = 0;
      checkEq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkEq("rst_out_data", {7'd0, out_data}, 32'd0);
      checkEq("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
      checkEq("rst_out_frac", {31'd0, out_frac}, 32'd0);
      checkEq("rst_ovf_cnt", {16'd0, ovf_cnt}, 32'd0);
    end else begin
      checkEq("ovf_cnt", {16'd0, ovf_cnt}, expCnt);
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkEq("out_valid_no_pending", {31'd0, out_valid}, 32'd0);
        end else begin
          h = expQ[0];
          checkEq("sb_data", {7'd0, out_data}, {7'd0, h.data});
          checkEq("sb_ovf", {31'd0, out_ovf}, {31'd0, h.ovf});
          checkEq("sb_frac", {31'd0, out_frac}, {31'd0, h.frac});
          if (out_ready) begin
            void'(expQ.pop_front());
            deliverCount++;
            if (h.ovf && expCnt != 16'hFFFF) expCnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(model(in_neg, in_int, in_frac));
        acceptCount++;
      end
    end
  end

  // Offer one word (call at posedge+1); returns at posedge+1 after acceptance.
  task automatic applyStimulus(input logic neg, input logic [INT_W-1:0] i, input logic [FRAC_W-1:0] f);
    int n;
    in_valid = 1'b1;
    in_neg   = neg;
    in_int   = i;
    in_frac  = f;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checkEq("accept_timeout", {31'd0, in_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_neg   = $urandom_range(0, 1);
    in_int   = INT_W'($urandom);
    in_frac  = FRAC_W'($urandom);
  endtask

  // Expects an empty pipeline and out_ready high; checks exact 2-cycle latency.
  task automatic checkOutput(input string name, input logic [W-1:0] data, input logic ovf, input logic frac);
    @(negedge clk);
    checkEq({name, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    checkEq({name, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
    checkEq({name, "_data"}, {7'd0, out_data}, {7'd0, data});
    checkEq({name, "_ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
    checkEq({name, "_frac"}, {31'd0, out_frac}, {31'd0, frac});
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkEq({name, "_drained"}, expQ.size(), 32'd0);
  endtask

  initial begin
    #200000;
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    int acc0;
    int del0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_neg    = 1'b0;
    in_int    = '0;
    in_frac   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkEq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkEq("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(1'b0, 15'd3, 10'h200);
    checkOutput("pos_frac", 25'h0000E00, 1'b0, 1'b1);
    applyStimulus(1'b1, 15'd1, 10'h000);
    checkOutput("neg_one", 25'h1FFFC00, 1'b0, 1'b0);

    checkEq("cnt_before_ovf", {16'd0, ovf_cnt}, 32'd0);
    applyStimulus(1'b0, 15'h4000, 10'h000);
    checkOutput("pos_sat", 25'h0FFFFFF, 1'b1, 1'b0);
    checkEq("cnt_after_ovf", {16'd0, ovf_cnt}, 32'd1);
    applyStimulus(1'b1, 15'h4000, 10'h000);
    checkOutput("neg_min", 25'h1000000, 1'b0, 1'b0);
    checkEq("cnt_after_min", {16'd0, ovf_cnt}, 32'd1);

    applyStimulus(1'b1, 15'd0, 10'h000);
    checkOutput("neg_zero", 25'h0000000, 1'b0, 1'b0);
    applyStimulus(1'b0, 15'h3FFF, 10'h3FF);
    checkOutput("pos_max", 25'h0FFFFFF, 1'b0, 1'b1);
    applyStimulus(1'b1, 15'h4000, 10'h001);
    checkOutput("neg_sat", 25'h1000000, 1'b1, 1'b1);
    applyStimulus(1'b0, 15'h7FFF, 10'h3FF);
    checkOutput("pos_sat_full", 25'h0FFFFFF, 1'b1, 1'b1);
    checkEq("cnt_after_three", {16'd0, ovf_cnt}, 32'd3);

    // Stall: four words offered back to back while downstream is blocked.
    acc0 = acceptCount;
    del0 = deliverCount;
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(1'b0, 15'd1, 10'h001);
        applyStimulus(1'b1, 15'd2, 10'h003);
        applyStimulus(1'b0, 15'h5000, 10'h000);
        applyStimulus(1'b1, 15'd0, 10'h005);
      end
      begin
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (c >= 2) checkEq("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        checkEq("stall_accepted", acceptCount - acc0, 32'd2);
        out_ready = 1'b1;
      end
    join
    waitDrain("stall");
    checkEq("stall_delivered", deliverCount - del0, 32'd4);

    // Reset with two words in flight.
    applyStimulus(1'b0, 15'h6000, 10'h000);
    applyStimulus(1'b1, 15'd7, 10'h007);
    checkEq("inflight_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkEq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkEq("mid_rst_ovf_cnt", {16'd0, ovf_cnt}, 32'd0);
    checkEq("mid_rst_out_data", {7'd0, out_data}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkEq("no_stale_word", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 15'd3, 10'h200);
    checkOutput("after_rst", 25'h0000E00, 1'b0, 1'b1);
    waitDrain("final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/merge_fixed.md
MERGE_FIXED -- requirements
Module: merge_fixed

Interface
REQ-001 SHALL have parameter INT_W, default 15, integer-magnitude width.
REQ-002 SHALL have parameter FRAC_W, default 10, fraction width; W = INT_W+FRAC_W (default 25) is the output width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input word offered.
REQ-006 SHALL have port in_ready  output  1  block can accept the input word this cycle.
REQ-007 SHALL have port in_neg  input  1  sign: 1 = negative.
REQ-008 SHALL have port in_int  input  INT_W  unsigned integer magnitude.
REQ-009 SHALL have port in_frac  input  FRAC_W  unsigned fractional magnitude.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have port out_data  output  W  signed two's-complement fixed point, FRAC_W fraction bits.
REQ-013 SHALL have port out_ovf  output  1  out_data was saturated; qualified by out_valid.
REQ-014 SHALL have port out_frac  output  1  in_frac was nonzero; qualified by out_valid.
REQ-015 SHALL have port ovf_cnt  output  16  count of saturated words delivered.

Function
REQ-016 SHALL accept an input word on a cycle where in_valid && in_ready, and deliver an output word on a cycle where out_valid && out_ready.
REQ-017 SHALL be a 2-stage pipeline: S1 registers mag = {in_int, in_frac} (W bits unsigned), neg, frac flag (|in_frac), and ovf flag; S2 registers out_data, out_ovf, out_frac.
REQ-018 SHALL set ovf in S1 when (neg==0 && mag > 2^(W-1)-1) or (neg==1 && mag > 2^(W-1)).
REQ-019 SHALL compute in S2: ovf && !neg -> 2^(W-1)-1; ovf && neg -> -2^(W-1); !ovf && !neg -> mag; !ovf && neg -> (~mag)+1, truncated to W bits.
REQ-020 SHALL output 0 for neg==1 with mag==0 (no negative zero), with out_ovf=0.
REQ-021 SHALL give a latency of exactly 2 cycles from acceptance to out_valid when out_ready stays high, with throughput of one word per cycle.
REQ-022 SHALL advance S2 when !S2.valid || out_ready, and advance S1 into S2 under the same condition.
REQ-023 SHALL drive in_ready = !S1.valid || S2 advancing; in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 SHALL hold out_data, out_ovf, out_frac stable while out_valid && !out_ready.
REQ-025 SHALL preserve order and never drop or duplicate a word under any out_ready pattern.
REQ-026 SHALL increment ovf_cnt by 1 on each delivered word with out_ovf=1, saturating at 16'hFFFF.
REQ-027 SHALL ignore in_neg, in_int, and in_frac when in_valid is low.

Reset
REQ-028 SHALL, while rst_n is low, clear S1.valid and S2.valid, with out_valid=0, out_data=0, out_ovf=0, out_frac=0, ovf_cnt=0, and in_ready=1 on the first cycle after release.
REQ-029 SHALL discard words held in the pipeline when reset is asserted mid-operation; none SHALL be delivered after reset.

Verification
REQ-030 SHALL pass: neg=0, int=3, frac=0x200, out_ready=1 -> out_data=25'h0000E00, out_frac=1, out_ovf=0, 2 cycles after acceptance.
REQ-031 SHALL pass: neg=1, int=1, frac=0 -> out_data=25'h1FFFC00 (-1024), out_frac=0, out_ovf=0.
REQ-032 SHALL pass: neg=0, int=0x4000, frac=0 -> out_data=25'h0FFFFFF, out_ovf=1, ovf_cnt 0->1; then neg=1 with the same values -> out_data=25'h1000000, out_ovf=0, ovf_cnt stays 1.
REQ-033 SHALL pass: neg=1, int=0, frac=0 -> out_data=0, out_ovf=0.
REQ-034 SHALL pass: 4 back-to-back words with out_ready=0 for 6 cycles -> exactly 2 accepted, in_ready=0 until out_ready rises, all 4 delivered in order, out_data stable while stalled.
REQ-035 SHALL pass: rst_n pulsed low while 2 words are in flight -> out_valid=0 immediately, ovf_cnt=0, no stale word appears after release.
